instr_rom_arbiter: RTL and testbench



---
 rtl/rom_arb_pkg.sv | 21 ++
 rtl/rom_addr_check.sv | 23 ++
 rtl/instr_rom_arbiter.sv | 111 +++++++++++
 tb/tb_instr_rom_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the instruction ROM arbiter: the ROM window, the response
// owner encoding and the one-entry response register layout.
package rom_arb_pkg;

    localparam logic [31:0] ROM_BASE = 32'hBFC0_0000;
    localparam logic [31:0] ROM_SIZE = 32'd4096;
    localparam int unsigned RESP_DATA_WIDTH = 32;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } owner_e;

    typedef struct packed {
        logic                       valid;
        owner_e                     owner;
        logic [RESP_DATA_WIDTH-1:0] data;
        logic                       err;
    } resp_t;

endpackage

// File: rtl/rom_addr_check.sv
// Converts an absolute requester address into a ROM byte offset and flags accesses that
// are misaligned or fall outside the ROM window.
module rom_addr_check
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned OFF_WIDTH  = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [OFF_WIDTH-1:0]  off_o,
    output logic                  legal_o
);

    logic [31:0] off_full;

    // Addresses below the base wrap to large offsets and fail the upper-bound test.
    always_comb begin
        off_full = 32'(addr_i) - ROM_BASE;
        off_o    = off_full[OFF_WIDTH-1:0];
        legal_o  = (addr_i[1:0] == 2'b00) && (off_full <= (ROM_SIZE - 32'd4));
    end

endmodule

// File: rtl/instr_rom_arbiter.sv
// Arbitrates the asynchronous-read ROM port between instruction fetch and the load unit,
// returning data through a one-entry registered response stage with back-pressure.
module instr_rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ROM_OFF_WIDTH = 12,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     if_req_i,
    input  logic [ADDR_WIDTH-1:0]    if_addr_i,
    output logic                     if_gnt_o,
    output logic                     if_rvalid_o,
    output logic [DATA_WIDTH-1:0]    if_rdata_o,
    output logic                     if_err_o,
    input  logic                     if_rready_i,

    input  logic                     ld_req_i,
    input  logic [ADDR_WIDTH-1:0]    ld_addr_i,
    output logic                     ld_gnt_o,
    output logic                     ld_rvalid_o,
    output logic [DATA_WIDTH-1:0]    ld_rdata_o,
    output logic                     ld_err_o,
    input  logic                     ld_rready_i,

    output logic [ROM_OFF_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0]    rom_dout_i
);

    localparam int unsigned CntWidth = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWidth-1:0] StarveMax = CntWidth'(STARVE_LIMIT);

    logic [ROM_OFF_WIDTH-1:0] if_off, ld_off;
    logic                     if_legal, ld_legal;

    rom_addr_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .OFF_WIDTH  (ROM_OFF_WIDTH)
    ) u_if_check (
        .addr_i  (if_addr_i),
        .off_o   (if_off),
        .legal_o (if_legal)
    );

    rom_addr_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .OFF_WIDTH  (ROM_OFF_WIDTH)
    ) u_ld_check (
        .addr_i  (ld_addr_i),
        .off_o   (ld_off),
        .legal_o (ld_legal)
    );

    resp_t               resp_d, resp_q;
    logic [CntWidth-1:0] starve_d, starve_q;
    logic                owner_rready, can_accept, if_win, ld_win, win_legal;

    always_comb begin
        owner_rready = (resp_q.owner == OWN_LD) ? ld_rready_i : if_rready_i;
        // Grants are held off while reset is asserted so the outputs read as idle.
        can_accept   = rst_ni && (!resp_q.valid || owner_rready);
        if_win       = can_accept && if_req_i && !(ld_req_i && (starve_q == StarveMax));
        ld_win       = can_accept && ld_req_i && !if_win;
        win_legal    = ld_win ? ld_legal : if_legal;

        resp_d = resp_q;
        if (if_win || ld_win) begin
            resp_d.valid = 1'b1;
            resp_d.owner = ld_win ? OWN_LD : OWN_IF;
            resp_d.data  = win_legal ? RESP_DATA_WIDTH'(rom_dout_i) : '0;
            resp_d.err   = !win_legal;
        end else if (resp_q.valid && owner_rready) begin
            resp_d.valid = 1'b0;
        end

        starve_d = starve_q;
        if (ld_win) begin
            starve_d = '0;
        end else if (ld_req_i && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q   <= '0;
            starve_q <= '0;
        end else begin
            resp_q   <= resp_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        if_gnt_o    = if_win;
        ld_gnt_o    = ld_win;
        rom_addr_o  = !rst_ni ? '0 : (ld_win ? ld_off : if_off);

        if_rvalid_o = resp_q.valid && (resp_q.owner == OWN_IF);
        ld_rvalid_o = resp_q.valid && (resp_q.owner == OWN_LD);
        if_rdata_o  = if_rvalid_o ? DATA_WIDTH'(resp_q.data) : '0;
        ld_rdata_o  = ld_rvalid_o ? DATA_WIDTH'(resp_q.data) : '0;
        if_err_o    = if_rvalid_o && resp_q.err;
        ld_err_o    = ld_rvalid_o && resp_q.err;
    end

endmodule

// File: tb/tb_instr_rom_arbiter.sv
// Scoreboard bench for instr_rom_arbiter: a negedge monitor predicts grants and responses
// from the window/arbitration rules and checks them while directed and random stimulus runs.
module tb_instr_rom_arbiter;

    localparam logic [31:0] BASE  = 32'hBFC0_0000;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, ld_req = 1'b0;
    logic [31:0] if_addr = BASE, ld_addr = BASE;
    logic        if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err;
    logic [31:0] if_rdata, ld_rdata, rom_dout;
    logic        if_rready = 1'b1, ld_rready = 1'b1;
    logic [11:0] rom_addr;

    logic [31:0] mem [1024];
    assign rom_dout = mem[rom_addr[11:2]];

    always #5 clk = ~clk;

    instr_rom_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .ROM_OFF_WIDTH (12),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .if_err_o    (if_err),
        .if_rready_i (if_rready),
        .ld_req_i    (ld_req),
        .ld_addr_i   (ld_addr),
        .ld_gnt_o    (ld_gnt),
        .ld_rvalid_o (ld_rvalid),
        .ld_rdata_o  (ld_rdata),
        .ld_err_o    (ld_err),
        .ld_rready_i (ld_rready),
        .rom_addr_o  (rom_addr),
        .rom_dout_i  (rom_dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] == 2'b00) && (off <= 32'd4092);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = BASE + 32'h0FFC;
            1: a = BASE + 32'h1000;
            2: a = BASE - 32'd4;
            3: a = BASE + (32'($urandom_range(0, 1023)) << 2) + 32'($urandom_range(1, 3));
            4: a = $urandom;
            default: a = BASE + (32'($urandom_range(0, 1023)) << 2);
        endcase
        return a;
    endfunction

    // Scoreboard: one expected response per accepted request, in grant order.
    typedef struct {
        bit          own_ld;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    exp_t        f, e;
    int unsigned ld_wait = 0;
    bit          full, drain, acc, w_if, w_ld;
    logic [31:0] waddr, woff;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_ctrl", 32'({if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err}), 0);
            check("reset_rdata", if_rdata | ld_rdata, 0);
            check("reset_rom_addr", 32'(rom_addr), 0);
            sb.delete();
            ld_wait = 0;
        end else begin
            full  = sb.size() != 0;
            drain = 1'b0;
            if (full) begin
                f = sb[0];
                check("if_rvalid", 32'(if_rvalid), 32'(!f.own_ld));
                check("ld_rvalid", 32'(ld_rvalid), 32'(f.own_ld));
                check("if_rdata", if_rdata, f.own_ld ? 32'd0 : f.data);
                check("ld_rdata", ld_rdata, f.own_ld ? f.data : 32'd0);
                check("if_err", 32'(if_err), 32'(!f.own_ld && f.err));
                check("ld_err", 32'(ld_err), 32'(f.own_ld && f.err));
                drain = f.own_ld ? ld_rready : if_rready;
            end else begin
                check("idle_rvalid", 32'({if_rvalid, ld_rvalid, if_err, ld_err}), 0);
            end
            if (drain) void'(sb.pop_front());
            acc  = !full || drain;
            w_if = acc && if_req && !(ld_req && ld_wait == LIMIT);
            w_ld = acc && ld_req && !w_if;
            check("if_gnt", 32'(if_gnt), 32'(w_if));
            check("ld_gnt", 32'(ld_gnt), 32'(w_ld));
            waddr = w_ld ? ld_addr : if_addr;
            woff  = waddr - BASE;
            check("rom_addr", 32'(rom_addr), woff & 32'hFFF);
            if (w_if || w_ld) begin
                e.own_ld = w_ld;
                e.err    = !legal(waddr);
                e.data   = e.err ? 32'd0 : mem[woff[11:2]];
                sb.push_back(e);
            end
            if (w_ld) ld_wait = 0;
            else if (ld_req && ld_wait < LIMIT) ld_wait++;
        end
    end

    task automatic request(input bit ld, input logic [31:0] addr);
        bit got;
        got = 1'b0;
        if (ld) begin
            ld_req = 1'b1; ld_addr = addr;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 0; c < 32 && !got; c++) begin
            @(negedge clk);
            got = ld ? ld_gnt : if_gnt;
        end
        check("grant_within_budget", 32'(got), 1);
        @(posedge clk);
        #1;
        if (ld) ld_req = 1'b0;
        else if_req = 1'b0;
    endtask

    task automatic contend(input int cycles);
        if_req = 1'b1; if_addr = BASE + 32'h100;
        ld_req = 1'b1; ld_addr = BASE + 32'h200;
        if_rready = 1'b1; ld_rready = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("starve_pattern", 32'({if_gnt, ld_gnt}), (k % 5 == 4) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
        end
        if_req = 1'b0; ld_req = 1'b0;
    endtask

    bit g_if, g_ld;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h0123_4567;
        mem[2] = 32'h89AB_CDEF;

        // Requests held during reset must not be granted.
        if_req = 1'b1; ld_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if_req = 1'b0; ld_req = 1'b0;
        rst_n = 1'b1;

        request(1'b0, BASE);
        @(negedge clk);
        check("first_if_rvalid", 32'(if_rvalid), 1);
        check("first_if_rdata", if_rdata, 32'hDEADBEEF);
        check("first_ld_rvalid", 32'(ld_rvalid), 0);
        @(posedge clk);
        #1;

        contend(15);
        @(posedge clk);
        #1;

        request(1'b1, BASE + 32'h0FFE);
        request(1'b1, BASE + 32'h1000);
        request(1'b1, BASE - 32'd4);
        @(posedge clk);
        #1;

        // Back-pressure: IF holds its response while LD waits.
        if_rready = 1'b0;
        request(1'b0, BASE + 32'h20);
        ld_req = 1'b1; ld_addr = BASE + 32'h40;
        repeat (3) begin
            @(negedge clk);
            check("bp_no_grant", 32'({if_gnt, ld_gnt}), 0);
            @(posedge clk);
            #1;
        end
        if_rready = 1'b1;
        @(negedge clk);
        check("drain_grant", 32'(ld_gnt), 1);
        @(posedge clk);
        #1;
        ld_req = 1'b0;

        request(1'b0, BASE);
        request(1'b0, BASE + 32'h4);
        request(1'b0, BASE + 32'h8);
        @(posedge clk);
        #1;

        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            g_if = if_gnt;
            g_ld = ld_gnt;
            @(posedge clk);
            #1;
            if (!if_req || g_if) begin
                if_req = ($urandom_range(0, 1) == 1);
                if_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!ld_req || g_ld) begin
                ld_req = ($urandom_range(0, 1) == 1);
                ld_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) begin
                ld_req = 1'b0;
            end
            if_rready = ($urandom_range(0, 3) != 0);
            ld_rready = ($urandom_range(0, 3) != 0);
        end
        if_req = 1'b0; ld_req = 1'b0;
        if_rready = 1'b1; ld_rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset with a response pending and LD partially starved.
        if_rready = 1'b0;
        ld_req = 1'b1; ld_addr = BASE + 32'h80;
        request(1'b0, BASE + 32'h10);
        #2;
        rst_n = 1'b0;
        ld_req = 1'b0;
        #1;
        check("reset_drops_rvalid", 32'({if_rvalid, ld_rvalid}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        if_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        contend(5);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
